// File: rtl/ws2812_strip_scheduler_pkg.sv
// Shared command codes, FSM state encoding and latch-time helper for the WS2812 strip scheduler.
// Pure declarations: no latency or backpressure of its own.
package ws2812_strip_scheduler_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Latch length in clocks, never below one so the timer always has a terminal count.
  function automatic int latch_cycles(input int clk_khz, input int latch_us);
    int cyc;
    cyc = (clk_khz * latch_us) / 1000;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/ws2812_strip_scheduler_if.sv
// Frame-buffer read port plus RGB-controller command handshake between scheduler and its neighbours.
// master = scheduler side; slave = frame-buffer RAM / controller side.
interface ws2812_strip_scheduler_if #(
  parameter int ADDR_W = 6
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_rdata;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic [1:0]        command;
  logic              cmd_wait;

  modport master (
    output fb_rd_en, fb_addr, r, g, b, command,
    input  fb_rdata, cmd_wait
  );

  modport slave (
    input  fb_rd_en, fb_addr, r, g, b, command,
    output fb_rdata, cmd_wait
  );
endinterface

// File: rtl/ws2812_strip_scheduler_latch_timer.sv
// Latch-time counter: load clears, run counts, tc_o is high on the LATCH_CYC-th running cycle.
// No backpressure; counter saturates and holds until the next load.
module ws2812_strip_scheduler_latch_timer #(
  parameter int LATCH_CYC = 2800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic tc_o
);
  localparam int CNT_W = $clog2(LATCH_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(LATCH_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/ws2812_strip_scheduler.sv
// Frame sequencer: reads len pixels from the frame buffer, hands each to the RGB controller, then latches.
// start -> first TX in 2 clks, 1-clk gap between pixels; stalls indefinitely while cmd_wait is low.
module ws2812_strip_scheduler
  import ws2812_strip_scheduler_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 10000,
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int LATCH_US     = 280
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        auto_mode_i,
  input  logic [ADDR_W:0]             len_i,
  output logic                        busy_o,
  output logic                        frame_done_o,
  ws2812_strip_scheduler_if.master    bus
);
  localparam int LATCH_CYC = latch_cycles(CLK_FREQ_KHZ, LATCH_US);
  localparam int LEN_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_LEDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [LEN_W-1:0]  len_clamp;
  logic [LEN_W-1:0]  idx_inc;
  logic              rd_en;
  logic              new_frame;
  logic              done;
  logic              tmr_load;
  logic              tmr_tc;

  assign len_clamp = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign idx_inc   = idx_q + ONE;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rgb_d     = rgb_q;
    rd_en     = 1'b0;
    tmr_load  = 1'b0;
    done      = 1'b0;
    new_frame = 1'b0;
    case (state_q)
      ST_IDLE: new_frame = start_i;
      ST_FETCH: begin
        rgb_d   = bus.fb_rdata;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.cmd_wait) begin
          idx_d = idx_inc;
          // Prefetch in the accept cycle so the controller sees only a one-clock gap.
          if (idx_inc < len_q) begin
            rd_en   = 1'b1;
            addr_d  = idx_inc[ADDR_W-1:0];
            state_d = ST_FETCH;
          end else begin
            tmr_load = 1'b1;
            state_d  = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (tmr_tc) begin
          done = 1'b1;
          if (auto_mode_i) begin
            new_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (new_frame) begin
      len_d = len_clamp;
      idx_d = '0;
      if (len_clamp == '0) begin
        tmr_load = 1'b1;
        state_d  = ST_LATCH;
      end else begin
        rd_en   = 1'b1;
        addr_d  = '0;
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
    end
  end

  ws2812_strip_scheduler_latch_timer #(
    .LATCH_CYC (LATCH_CYC)
  ) u_latch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .run_i  (state_q == ST_LATCH),
    .tc_o   (tmr_tc)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done;
  assign bus.fb_rd_en = rd_en;
  assign bus.fb_addr  = addr_d;
  assign bus.r        = rgb_q[23:16];
  assign bus.g        = rgb_q[15:8];
  assign bus.b        = rgb_q[7:0];
  assign bus.command  = (state_q == ST_SEND) ? CMD_TX : CMD_IDLE;

endmodule

// File: tb/tb_ws2812_strip_scheduler.sv
// Directed bench for ws2812_strip_scheduler: frame vector table plus start-ignore, auto-mode and reset sequences.
module tb_ws2812_strip_scheduler;
  import ws2812_strip_scheduler_pkg::*;

  localparam int ADDR_W    = 6;
  localparam int LATCH_CYC = 2800;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            start     = 1'b0;
  logic            auto_mode = 1'b0;
  logic [ADDR_W:0] len_r     = '0;
  logic            busy;
  logic            frame_done;

  ws2812_strip_scheduler_if #(.ADDR_W(ADDR_W)) bus();

  ws2812_strip_scheduler #(
    .CLK_FREQ_KHZ (10000),
    .NUM_LEDS     (64),
    .ADDR_W       (ADDR_W),
    .LATCH_US     (280)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .auto_mode_i  (auto_mode),
    .len_i        (len_r),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [64];
  always @(posedge clk) if (bus.fb_rd_en) bus.fb_rdata <= mem[bus.fb_addr];

  // Controller model: holds cmd_wait low for stall_cfg cycles of each TX presentation.
  int stall_cfg = 0;
  int wcnt      = 0;
  always @(posedge clk) begin
    #1;
    if (bus.command == CMD_TX) begin
      bus.cmd_wait = (wcnt >= stall_cfg);
      wcnt++;
    end else begin
      bus.cmd_wait = 1'b0;
      wcnt = 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0, acc_cnt = 0, fd_cnt = 0, busy_cnt = 0;
  int addr_err = 0, pix_err = 0, stab_err = 0;
  int rd_idx = 0, acc_idx = 0;
  int first_acc_cyc = 0, last_acc_cyc = 0, fd_cyc = 0, prev_fd_cyc = 0, last_addr = 0;
  logic        prev_tx = 1'b0, prev_acc = 1'b0, mon_tx, mon_acc;
  logic [23:0] prev_rgb = '0, mon_rgb;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_idx  = 0;
      acc_idx = 0;
      prev_tx = 1'b0;
      prev_acc = 1'b0;
    end else begin
      mon_rgb = {bus.r, bus.g, bus.b};
      mon_tx  = (bus.command == CMD_TX);
      mon_acc = mon_tx && bus.cmd_wait;
      if (busy) busy_cnt++;
      if (frame_done) begin
        fd_cnt++;
        prev_fd_cyc = fd_cyc;
        fd_cyc      = cyc;
        rd_idx      = 0;
        acc_idx     = 0;
      end
      if (bus.fb_rd_en) begin
        rd_cnt++;
        last_addr = int'(bus.fb_addr);
        if (int'(bus.fb_addr) != rd_idx) addr_err++;
        rd_idx++;
      end
      if (mon_tx && prev_tx && !prev_acc && (mon_rgb != prev_rgb)) stab_err++;
      if (mon_acc) begin
        acc_cnt++;
        if (acc_idx == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        if (acc_idx > 63 || mon_rgb != mem[acc_idx]) pix_err++;
        acc_idx++;
      end
      prev_tx  = mon_tx;
      prev_acc = mon_acc;
      prev_rgb = mon_rgb;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int len, input int stall, output int s_cyc);
    stall_cfg = stall;
    @(posedge clk); #1;
    start = 1'b1;
    len_r = (ADDR_W+1)'(len);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_in_budget", 64'(fd_cnt >= target), 64'd1);
  endtask

  typedef struct {
    int len;
    int stall;
    int exp_n;
    int exp_busy;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b0, a0, r0, f0, n;
    vecs[0] = '{len: 3,   stall: 0,  exp_n: 3,  exp_busy: 2806};
    vecs[1] = '{len: 2,   stall: 50, exp_n: 2,  exp_busy: 2904};
    vecs[2] = '{len: 0,   stall: 0,  exp_n: 0,  exp_busy: 2800};
    vecs[3] = '{len: 100, stall: 0,  exp_n: 64, exp_busy: 2928};
    vecs[4] = '{len: 1,   stall: 3,  exp_n: 1,  exp_busy: 2805};
    for (int i = 0; i < 64; i++) mem[i] = {8'(i*3+1), 8'(i*5+2), 8'(i*7+3)};
    mem[0] = 24'h112233;
    mem[1] = 24'h445566;
    mem[2] = 24'h778899;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, frame_done, bus.fb_rd_en, bus.fb_addr, bus.r, bus.g, bus.b, bus.command}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      b0 = busy_cnt; a0 = acc_cnt; r0 = rd_cnt; f0 = fd_cnt;
      run_frame(vecs[i].len, vecs[i].stall, s);
      wait_fd(f0 + 1, 3500 + vecs[i].len * (vecs[i].stall + 2));
      #1;
      check($sformatf("v%0d_frame_done_cnt", i), 64'(fd_cnt - f0), 64'd1);
      check($sformatf("v%0d_accepts", i), 64'(acc_cnt - a0), 64'(vecs[i].exp_n));
      check($sformatf("v%0d_rd_pulses", i), 64'(rd_cnt - r0), 64'(vecs[i].exp_n));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt - b0), 64'(vecs[i].exp_busy));
      check($sformatf("v%0d_start_to_done", i), 64'(fd_cyc - s), 64'(vecs[i].exp_busy));
      check($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
      if (vecs[i].exp_n > 0) begin
        check($sformatf("v%0d_first_tx_latency", i), 64'(first_acc_cyc - s), 64'(2 + vecs[i].stall));
        check($sformatf("v%0d_pixel_spacing", i), 64'(last_acc_cyc - first_acc_cyc),
              64'((vecs[i].stall + 2) * (vecs[i].exp_n - 1)));
        check($sformatf("v%0d_latch_len", i), 64'(fd_cyc - last_acc_cyc), 64'(LATCH_CYC));
        check($sformatf("v%0d_last_addr", i), 64'(last_addr), 64'(vecs[i].exp_n - 1));
      end
    end
    check("table_addr_errors", 64'(addr_err), 64'd0);
    check("table_pixel_errors", 64'(pix_err), 64'd0);
    check("table_stall_stability", 64'(stab_err), 64'd0);

    // Extra start pulses mid-frame and during latch, with len changed while busy.
    b0 = busy_cnt; a0 = acc_cnt; r0 = rd_cnt; f0 = fd_cnt;
    run_frame(4, 0, s);
    len_r = 7'd7;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_fd(f0 + 1, 3500);
    #1;
    check("ign_accepts", 64'(acc_cnt - a0), 64'd4);
    check("ign_rd_pulses", 64'(rd_cnt - r0), 64'd4);
    check("ign_start_to_done", 64'(fd_cyc - s), 64'd2808);
    repeat (3000) @(posedge clk);
    #1;
    check("ign_single_done", 64'(fd_cnt - f0), 64'd1);
    check("ign_no_new_frame", 64'(busy_cnt - b0), 64'd2808);

    // Auto mode: three back-to-back frames of 4 pixels.
    b0 = busy_cnt; a0 = acc_cnt; r0 = rd_cnt; f0 = fd_cnt;
    auto_mode = 1'b1;
    run_frame(4, 0, s);
    wait_fd(f0 + 2, 6000);
    #1 auto_mode = 1'b0;
    wait_fd(f0 + 3, 3500);
    #1;
    check("auto_done_cnt", 64'(fd_cnt - f0), 64'd3);
    check("auto_accepts", 64'(acc_cnt - a0), 64'd12);
    check("auto_rd_pulses", 64'(rd_cnt - r0), 64'd12);
    check("auto_busy_continuous", 64'(busy_cnt - b0), 64'd8424);
    check("auto_frame_period", 64'(fd_cyc - prev_fd_cyc), 64'd2808);
    check("auto_addr_restart", 64'(addr_err), 64'd0);
    check("auto_busy_after", 64'(busy), 64'd0);

    // Reset while pixel 2 of 5 is being presented.
    a0 = acc_cnt; f0 = fd_cnt;
    run_frame(5, 10, s);
    n = 0;
    while (!((acc_cnt - a0 == 2) && (bus.command == CMD_TX)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reached_pixel2", 64'(acc_cnt - a0), 64'd2);
    check("rst_pixel2_shown", 64'({bus.r, bus.g, bus.b}), 64'(mem[2]));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({busy, frame_done, bus.fb_rd_en, bus.fb_addr, bus.r, bus.g, bus.b, bus.command}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    check("rst_no_frame_done", 64'(fd_cnt - f0), 64'd0);
    a0 = acc_cnt; r0 = rd_cnt;
    run_frame(5, 0, s);
    wait_fd(f0 + 1, 3500);
    #1;
    check("rst_replay_accepts", 64'(acc_cnt - a0), 64'd5);
    check("rst_replay_rd", 64'(rd_cnt - r0), 64'd5);
    check("rst_replay_timing", 64'(fd_cyc - s), 64'd2810);
    check("final_addr_errors", 64'(addr_err), 64'd0);
    check("final_pixel_errors", 64'(pix_err), 64'd0);
    check("final_stall_stability", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
